// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared constants, lane encodings and state enum for the demux dispatch controller
package dmux_pkg;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 2;
  localparam int LANES  = 4;

  localparam logic [SEL_W-1:0] LANE_A = 2'd0;
  localparam logic [SEL_W-1:0] LANE_B = 2'd1;
  localparam logic [SEL_W-1:0] LANE_C = 2'd2;
  localparam logic [SEL_W-1:0] LANE_D = 2'd3;

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_e;
endpackage

// File: rtl/dmux_fifo.sv
// rtl/dmux_fifo.sv - synchronous in-order FIFO with push/pop/full/empty/count
module dmux_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is not reset; only the pointers and occupancy define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dmux_dispatch_ctrl.sv
// rtl/dmux_dispatch_ctrl.sv - FIFO-buffered lane dispatcher feeding the 1x4 demux; optional DISPATCH_RR_EN round-robin lanes
import dmux_pkg::*;

module dmux_dispatch_ctrl #(
  parameter int DATA_W = dmux_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_dest,
  output logic                      in_ready,
  input  logic [LANES-1:0]          lane_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          sel,
  output logic [LANES-1:0]          out_valid,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef DISPATCH_RR_EN
  localparam int FIFO_W = DATA_W;
`else
  localparam int FIFO_W = DATA_W + SEL_W;
`endif

  state_e             r_state;
  logic [FIFO_W-1:0]  w_fifo_wdata;
  logic [FIFO_W-1:0]  w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_next_count;
  logic [DATA_W-1:0]  w_head_data;
  logic [SEL_W-1:0]   w_head_dest;
  logic               w_push;
  logic               w_issue;

`ifdef DISPATCH_RR_EN
  logic [SEL_W-1:0]   r_rr;

  assign w_fifo_wdata = in_data;
  assign w_head_data  = w_fifo_rdata;
  assign w_head_dest  = r_rr;

  always_ff @(posedge clk) begin
    if (rst)          r_rr <= '0;
    else if (w_issue) r_rr <= r_rr + SEL_W'(1);
  end
`else
  assign w_fifo_wdata = {in_dest, in_data};
  assign w_head_data  = w_fifo_rdata[DATA_W-1:0];
  assign w_head_dest  = w_fifo_rdata[DATA_W +: SEL_W];
`endif

  // in_ready reflects pre-edge state, so a pop at the full edge cannot admit a word the same cycle.
  assign in_ready = !rst && (r_state != FULL) && !w_fifo_full;
  assign w_push   = in_valid && in_ready;
  assign w_issue  = (r_state != EMPTY) && !w_fifo_empty && lane_ready[w_head_dest];
  assign count    = w_count;

  dmux_fifo #(.WIDTH(FIFO_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_fifo_wdata),
    .pop   (w_issue),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_count)
  );

  always_comb begin
    w_next_count = w_count;
    if (w_push && !w_issue)      w_next_count = w_count + CNT_W'(1);
    else if (w_issue && !w_push) w_next_count = w_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else if (w_next_count == '0) begin
      r_state <= EMPTY;
    end else if (w_next_count == CNT_W'(DEPTH)) begin
      r_state <= FULL;
    end else begin
      r_state <= ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      sel       <= '0;
      out_valid <= '0;
    end else if (w_issue) begin
      out_data  <= w_head_data;
      sel       <= w_head_dest;
      out_valid <= LANES'(1) << w_head_dest;
    end else begin
      out_valid <= '0;
    end
  end
endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// tb/tb_dmux_dispatch_ctrl.sv - scoreboard bench for dmux_dispatch_ctrl
module tb_dmux_dispatch_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic [1:0] in_dest;
  logic       in_ready;
  logic [3:0] lane_ready;
  logic [3:0] out_data;
  logic [1:0] sel;
  logic [3:0] out_valid;
  logic [2:0] count;

  int n_pass  = 0;
  int n_total = 0;
  int n_issue = 0;
  int run_len = 0;
  int max_run = 0;

  logic [5:0] exp_q[$];

  dmux_dispatch_ctrl #(.DATA_W(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_ready   (in_ready),
    .lane_ready (lane_ready),
    .out_data   (out_data),
    .sel        (sel),
    .out_valid  (out_valid),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] d, input logic [1:0] dest, input bit accept);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dest;
    chk("in_ready_before_push", int'(in_ready), int'(accept));
    if (accept) exp_q.push_back({dest, d});
    step();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    logic [3:0] onehot;
    if (out_valid != 4'b0) begin
      n_issue++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_issue: out_valid=%b data=%h sel=%0d with nothing expected", out_valid, out_data, sel);
      end else begin
        e = exp_q.pop_front();
        onehot = 4'b0001 << e[5:4];
        chk("issue_out_valid", int'(out_valid), int'(onehot));
        chk("issue_out_data", int'(out_data), int'(e[3:0]));
        chk("issue_sel", int'(sel), int'(e[5:4]));
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'h9; in_dest = 2'd1; lane_ready = 4'hF;
    #1;
    chk("reset_in_ready_low", int'(in_ready), 0);
    step();
    step();
    chk("reset_count", int'(count), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_sel", int'(sel), 0);
    chk("reset_in_ready_still_low", int'(in_ready), 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_reset_in_ready", int'(in_ready), 1);

    // single word: no bypass, one-cycle strobe
    push_word(4'hA, 2'd2, 1'b1);
    chk("single_no_bypass", int'(out_valid), 0);
    step();
    chk("single_strobe", int'(out_valid), 4'b0100);
    step();
    chk("single_strobe_gone", int'(out_valid), 0);
    chk("single_data_held", int'(out_data), 4'hA);
    chk("single_sel_held", int'(sel), 2);

    // sweep all lanes back-to-back
    max_run = 0;
    base = n_issue;
    for (int i = 0; i < 16; i++) push_word(4'(i), 2'(i % 4), 1'b1);
    step(); step();
    chk("sweep_issue_count", n_issue - base, 16);
    chk("sweep_no_gaps", max_run, 16);

    // backpressure / full
    lane_ready = 4'h0;
    push_word(4'h1, 2'd0, 1'b1);
    push_word(4'h2, 2'd1, 1'b1);
    push_word(4'h3, 2'd2, 1'b1);
    push_word(4'h4, 2'd3, 1'b1);
    push_word(4'h5, 2'd0, 1'b0);
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    lane_ready = 4'hF;
    #1;
    chk("full_issue_no_reopen", int'(in_ready), 0);
    step();
    chk("full_after_one_issue_count", int'(count), 3);
    step(); step(); step(); step();
    chk("drain_count", int'(count), 0);
    chk("drain_in_ready", int'(in_ready), 1);

    // head-of-line blocking
    lane_ready = 4'b1101;
    base = n_issue;
    push_word(4'h3, 2'd1, 1'b1);
    push_word(4'h7, 2'd0, 1'b1);
    step(); step(); step();
    chk("hol_no_issue", n_issue - base, 0);
    chk("hol_count", int'(count), 2);
    lane_ready = 4'hF;
    step(); step(); step();
    chk("hol_issue_count", n_issue - base, 2);
    chk("hol_drained", int'(count), 0);

    // reset mid-stream
    lane_ready = 4'h0;
    push_word(4'h6, 2'd0, 1'b1);
    push_word(4'h8, 2'd1, 1'b1);
    push_word(4'h9, 2'd2, 1'b1);
    chk("pre_reset_count", int'(count), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("midreset_count", int'(count), 0);
    chk("midreset_out_valid", int'(out_valid), 0);
    lane_ready = 4'hF;
    base = n_issue;
    step(); step();
    chk("midreset_nothing_issued", n_issue - base, 0);
    push_word(4'h5, 2'd3, 1'b1);
    step();
    chk("fresh_strobe_lane_d", int'(out_valid), 4'b1000);
    step(); step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
